// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: controller state encoding.
package serial_adder_pkg;

  // Encoding 2'd3 is never entered; the FSM treats it as IDLE.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_adder_fulladder.sv
// Single-bit full adder cell; the only arithmetic in the serial adder.
module fullAdder (
  output logic sum,
  output logic cout,
  input  logic a,
  input  logic b,
  input  logic cin
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell plus a carry flip-flop,
// walking the operands LSB-first, with a start/busy/done handshake.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_s;
  logic             fa_c;

  fullAdder u_fa (
    .sum  (fa_s),
    .cout (fa_c),
    .a    (opa[0]),
    .b    (opb[0]),
    .cin  (carry)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      opa   <= '0;
      opb   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            opa   <= a;
            opb   <= b;
            carry <= cin;
            cnt   <= '0;
            sum   <= '0;
            busy  <= 1'b1;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          // Result fills from the top so the LSB lands in bit 0 after WIDTH steps.
          sum   <= {fa_s, sum[WIDTH-1:1]};
          carry <= fa_c;
          opa   <= opa >> 1;
          opb   <= opb >> 1;
          cnt   <= cnt + CW'(1);
          if (cnt == LAST) begin
            cout  <= fa_c;
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: scoreboard of expected {cout,sum}.
module tb_serial_adder;

  localparam int W     = 8;
  localparam int LIMIT = 3 * W;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  logic [W:0] exp_q[$];
  int passed = 0;
  int total  = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                       input logic c);
    return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
  endfunction

  // Drives one accepted start, pushes the expected result, then waits for done.
  task automatic do_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic,
                       output int lat, output logic [W:0] obs, output logic busy_ok);
    a = ia; b = ib; cin = ic; start = 1'b1;
    exp_q.push_back(model(ia, ib, ic));
    tick();
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    lat = 0;
    busy_ok = busy;
    while (!done && lat < LIMIT) begin
      tick();
      lat++;
      busy_ok = busy_ok & busy;
    end
    if (!done) lat = -1;
    obs = {cout, sum};
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    tick(); tick();
    total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passed++;
    total++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else passed++;
    total++; if (sum !== '0) $display("FAIL reset_sum: got %h expected 00", sum); else passed++;
    total++; if (cout !== 1'b0) $display("FAIL reset_cout: got %b expected 0", cout); else passed++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [W-1:0] va[3] = '{8'h03, 8'hFF, 8'hFF};
    logic [W-1:0] vb[3] = '{8'h05, 8'h01, 8'hFF};
    logic         vc[3] = '{1'b0, 1'b0, 1'b1};
    logic [W:0]   want[3] = '{9'h008, 9'h100, 9'h1FF};
    int lat;
    logic [W:0] obs;
    logic [W:0] exp;
    logic bok;
    for (int i = 0; i < 3; i++) begin
      do_op(va[i], vb[i], vc[i], lat, obs, bok);
      exp = exp_q.pop_front();
      total++; if (obs !== exp) $display("FAIL basic_result[%0d]: got %h expected %h", i, obs, exp); else passed++;
      total++; if (obs !== want[i]) $display("FAIL basic_const[%0d]: got %h expected %h", i, obs, want[i]); else passed++;
      total++; if (lat !== W) $display("FAIL basic_latency[%0d]: got %0d expected %0d", i, lat, W); else passed++;
      total++; if (bok !== 1'b1) $display("FAIL basic_busy[%0d]: got %b expected 1", i, bok); else passed++;
      tick();
      total++; if (done !== 1'b0) $display("FAIL basic_done_pulse[%0d]: got %b expected 0", i, done); else passed++;
      total++; if (obs !== {cout, sum}) $display("FAIL basic_hold[%0d]: got %h expected %h", i, {cout, sum}, obs); else passed++;
    end
  endtask

  task automatic test_start_ignored();
    int lat;
    int dones;
    logic [W:0] exp;
    a = 8'd3; b = 8'd5; cin = 1'b0; start = 1'b1;
    exp_q.push_back(model(8'd3, 8'd5, 1'b0));
    tick();
    a = 8'd1; b = 8'd1;
    lat = 0;
    while (!done && lat < LIMIT) begin
      tick();
      lat++;
    end
    start = 1'b0;
    exp = exp_q.pop_front();
    total++; if ({cout, sum} !== exp) $display("FAIL ignored_result: got %h expected %h", {cout, sum}, exp); else passed++;
    total++; if (lat !== W) $display("FAIL ignored_latency: got %0d expected %0d", lat, W); else passed++;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) dones++;
    end
    total++; if (dones !== 0) $display("FAIL ignored_extra_done: got %0d expected 0", dones); else passed++;
  endtask

  task automatic test_reset_mid_run();
    int lat;
    int dones;
    logic [W:0] obs;
    logic [W:0] exp;
    logic bok;
    a = 8'd3; b = 8'd5; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rst_n = 1'b0;
    tick();
    total++; if (busy !== 1'b0) $display("FAIL abort_busy: got %b expected 0", busy); else passed++;
    total++; if (sum !== '0) $display("FAIL abort_sum: got %h expected 00", sum); else passed++;
    total++; if (cout !== 1'b0) $display("FAIL abort_cout: got %b expected 0", cout); else passed++;
    total++; if (done !== 1'b0) $display("FAIL abort_done: got %b expected 0", done); else passed++;
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) dones++;
    end
    total++; if (dones !== 0) $display("FAIL abort_late_done: got %0d expected 0", dones); else passed++;
    do_op(8'd10, 8'd20, 1'b0, lat, obs, bok);
    exp = exp_q.pop_front();
    total++; if (obs !== exp) $display("FAIL abort_restart: got %h expected %h", obs, exp); else passed++;
    total++; if (obs !== 9'h01E) $display("FAIL abort_restart_const: got %h expected 01e", obs); else passed++;
    tick();
  endtask

  task automatic test_back_to_back();
    int gap;
    logic [W:0] exp;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic rc;
    ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
    a = ra; b = rb; cin = rc; start = 1'b1;
    exp_q.push_back(model(ra, rb, rc));
    for (int i = 0; i < 200; i++) begin
      gap = 0;
      do begin
        tick();
        gap++;
      end while (!done && gap < LIMIT);
      if (!done) begin
        total++;
        $display("FAIL b2b_timeout[%0d]: got no done after %0d cycles expected done", i, gap);
        start = 1'b0;
        return;
      end
      if (i < 199) begin
        ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
        a = ra; b = rb; cin = rc;
        exp_q.push_back(model(ra, rb, rc));
      end else begin
        start = 1'b0;
      end
      exp = exp_q.pop_front();
      total++; if ({cout, sum} !== exp) $display("FAIL b2b_result[%0d]: got %h expected %h", i, {cout, sum}, exp); else passed++;
      total++;
      if (gap !== ((i == 0) ? W + 1 : W + 2))
        $display("FAIL b2b_spacing[%0d]: got %0d expected %0d", i, gap, (i == 0) ? W + 1 : W + 2);
      else passed++;
    end
    tick(); tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_start_ignored();
    test_reset_mid_run();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
